snake_seg_monitor: RTL and testbench
====================================

SNAKE_SEG_MONITOR -- requirements
Module: snake_seg_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, the consecutive synced cycles a pattern must hold before acceptance (legal range 2..15).
REQ-002 SHALL have parameter CNT_W, default 16, the move_count width.
REQ-003 SHALL have port clk, input, 1, clock; every register uses its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port seg_in, input, 7, asynchronous segment bus; bit i = segment i (0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle); 1 = lit.
REQ-006 SHALL have port dp_in, input, 1, asynchronous decimal-point line.
REQ-007 SHALL have port head, output, 3, current snake head segment index.
REQ-008 SHALL have port head_valid, output, 1, head is known (state TRACK).
REQ-009 SHALL have port dir, output, 1, 0 = clockwise, 1 = counter-clockwise.
REQ-010 SHALL have port move_pulse, output, 1, one-cycle pulse per legal move.
REQ-011 SHALL have port move_count, output, CNT_W, count of legal moves; wraps.
REQ-012 SHALL have port dp_count, output, 8, count of dp rising edges; saturates at 255.
REQ-013 SHALL have port err_pulse, output, 1, one-cycle pulse per illegal frame.
REQ-014 SHALL have port err_code, output, 2, cause of the last error: 1 popcount, 2 delta, 3 adjacency; holds until the next error.
REQ-015 SHALL have port locked, output, 1, state is ARMED or TRACK.

Function
REQ-016 SHALL pass seg_in and dp_in through two-flop synchronizers.
REQ-017 SHALL hold a candidate pattern and a stability counter: a synced value different from the candidate loads the candidate with counter=1; an equal value increments the counter, saturating at STABLE_CYCLES.
REQ-018 SHALL accept the candidate as a new frame on the edge after the counter reaches STABLE_CYCLES, only if it differs from the last accepted frame; seg_in held constant yields move_pulse/err_pulse high during the cycle following rising edge STABLE_CYCLES+3 after the change.
REQ-019 SHALL ignore any seg_in glitch shorter than STABLE_CYCLES synced cycles.
REQ-020 SHALL implement states SYNC, ARMED and TRACK.
REQ-021 SHALL, in SYNC, treat an accepted frame with popcount 3 as the reference frame and move to ARMED, and treat any other frame as err_code 1 and stay in SYNC.
REQ-022 SHALL, in ARMED or TRACK, raise err_code 1 for a new frame with popcount not 3, then go to SYNC.
REQ-023 SHALL, in ARMED or TRACK, raise err_code 2 for a popcount-3 frame not differing from the reference by exactly one segment added and one removed, then take that frame as the reference and go to ARMED.
REQ-024 SHALL use adjacency sets 0:{1,5} 1:{0,2,6} 2:{1,3,6} 3:{2,4} 4:{3,5,6} 5:{0,4,6} 6:{1,2,4,5}.
REQ-025 SHALL, in ARMED, on a legal delta, set head to the added segment, go to TRACK, pulse move_pulse, increment move_count, and leave dir unchanged.
REQ-026 SHALL, in TRACK, on a legal delta with the added segment adjacent to head, pulse move_pulse, increment move_count and update head; otherwise raise err_code 3, take the frame as the reference and go to ARMED.
REQ-027 SHALL, on a legal TRACK move where both old and new head are in 0..5, set dir=0 if new = old+1 mod 6 and dir=1 if new = old-1 mod 6; moves into or out of 6 keep dir.
REQ-028 SHALL update the reference frame on every accepted frame.
REQ-029 SHALL count synced dp_in 0->1 transitions into dp_count without filtering.
REQ-030 SHALL never assert move_pulse and err_pulse in the same cycle.
REQ-031 SHALL have all outputs registered.

Reset
REQ-032 SHALL, while rst_n=0, force state SYNC, all outputs to 0, synchronizers, candidate, counter and reference frame to 0, regardless of clk; mid-operation reset discards the in-flight frame.

Verification
REQ-033 SHALL cover: reset asserted mid-move -> all outputs 0, locked=0; first frame after release needs full sync again.
REQ-034 SHALL cover: 0x31, 0x23, 0x07 each held 10 cycles -> locked, head 1 then 2, head_valid=1, dir=0, move_count=2, two move_pulses.
REQ-035 SHALL cover: 0x31, 0x38, 0x1C -> head 3 then 2, dir=1, move_count=2.
REQ-036 SHALL cover: from TRACK at 0x07, 0x16 -> err_code 3, ARMED; 0x07->0x58 -> err_code 2; 0x0F -> err_code 1, SYNC, locked=0.
REQ-037 SHALL cover: 0x23 glitch for STABLE_CYCLES-1 cycles on a stable 0x31 -> no pulse, no count change.
REQ-038 SHALL cover: 300 dp_in pulses -> dp_count=255; move_count wraps from 2^CNT_W-1 to 0.

Source files
------------

// File: rtl/snake_seg_monitor.sv
// Watches an asynchronous 7-segment bus showing a 3-segment "snake", debounces
// each pattern, and tracks head position, direction, legal moves and errors.
module snake_seg_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    input  logic             dp_in,
    output logic [2:0]       head,
    output logic             head_valid,
    output logic             dir,
    output logic             move_pulse,
    output logic [CNT_W-1:0] move_count,
    output logic [7:0]       dp_count,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             locked
);

    // state | meaning
    // SYNC  | no reference frame yet, waiting for a popcount-3 frame
    // ARMED | reference frame known, head not yet known
    // TRACK | head known, moves checked against adjacency
    typedef enum logic [1:0] {SYNC, ARMED, TRACK} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    localparam logic [1:0] ERR_POP = 2'd1;
    localparam logic [1:0] ERR_DELTA = 2'd2;
    localparam logic [1:0] ERR_ADJ = 2'd3;

    state_t     state, state_nx;
    logic [6:0] seg_s1, seg_s2;
    logic       dp_s1, dp_s2, dp_d;
    logic [6:0] cand;
    logic [3:0] stab_cnt;
    logic [6:0] ref_frame, ref_nx;

    logic       accept;
    logic [6:0] added, removed;
    logic [2:0] add_idx;
    logic [6:0] head_adj;
    logic [2:0] head_cw, head_ccw;
    logic       delta_ok;

    logic [2:0] head_nx;
    logic       dir_nx;
    logic       move_nx;
    logic       err_nx;
    logic [1:0] code_nx;

    function automatic logic [2:0] popcnt7(input logic [6:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 7; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [2:0] seg_index(input logic [6:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 7; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [6:0] adj_mask(input logic [2:0] s);
        logic [6:0] m;
        case (s)
            3'd0:    m = 7'b0100010;
            3'd1:    m = 7'b1000101;
            3'd2:    m = 7'b1001010;
            3'd3:    m = 7'b0010100;
            3'd4:    m = 7'b1101000;
            3'd5:    m = 7'b1010001;
            3'd6:    m = 7'b0110110;
            default: m = 7'b0000000;
        endcase
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            dp_s1  <= 1'b0;
            dp_s2  <= 1'b0;
            dp_d   <= 1'b0;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            dp_s1  <= dp_in;
            dp_s2  <= dp_s1;
            dp_d   <= dp_s2;
        end
    end

    // Candidate debounce: any change restarts the count at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= '0;
            stab_cnt <= '0;
        end else if (seg_s2 != cand) begin
            cand     <= seg_s2;
            stab_cnt <= 4'd1;
        end else if (stab_cnt != STABLE) begin
            stab_cnt <= stab_cnt + 4'd1;
        end
    end

    assign accept   = (stab_cnt == STABLE) && (cand != ref_frame);
    assign added    = cand & ~ref_frame;
    assign removed  = ref_frame & ~cand;
    assign add_idx  = seg_index(added);
    assign head_adj = adj_mask(head);
    assign head_cw  = (head == 3'd5) ? 3'd0 : head + 3'd1;
    assign head_ccw = (head == 3'd0) ? 3'd5 : head - 3'd1;
    assign delta_ok = (popcnt7(added) == 3'd1) && (popcnt7(removed) == 3'd1);

    always_comb begin
        state_nx = state;
        ref_nx   = ref_frame;
        head_nx  = head;
        dir_nx   = dir;
        move_nx  = 1'b0;
        err_nx   = 1'b0;
        code_nx  = err_code;
        if (accept) begin
            ref_nx = cand;
            if (popcnt7(cand) != 3'd3) begin
                err_nx   = 1'b1;
                code_nx  = ERR_POP;
                state_nx = SYNC;
            end else if (state == SYNC) begin
                state_nx = ARMED;
            end else if (!delta_ok) begin
                err_nx   = 1'b1;
                code_nx  = ERR_DELTA;
                state_nx = ARMED;
            end else if (state == ARMED) begin
                move_nx  = 1'b1;
                head_nx  = add_idx;
                state_nx = TRACK;
            end else if (head_adj[add_idx]) begin
                move_nx = 1'b1;
                head_nx = add_idx;
                // Ring moves set direction; moves through the middle keep it.
                if (head != 3'd6 && add_idx != 3'd6) begin
                    if (add_idx == head_cw) begin
                        dir_nx = 1'b0;
                    end else if (add_idx == head_ccw) begin
                        dir_nx = 1'b1;
                    end
                end
            end else begin
                err_nx   = 1'b1;
                code_nx  = ERR_ADJ;
                state_nx = ARMED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            ref_frame  <= '0;
            head       <= '0;
            head_valid <= 1'b0;
            dir        <= 1'b0;
            move_pulse <= 1'b0;
            move_count <= '0;
            err_pulse  <= 1'b0;
            err_code   <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nx;
            ref_frame  <= ref_nx;
            head       <= head_nx;
            head_valid <= (state_nx == TRACK);
            dir        <= dir_nx;
            move_pulse <= move_nx;
            move_count <= move_count + CNT_W'(move_nx);
            err_pulse  <= err_nx;
            err_code   <= code_nx;
            locked     <= (state_nx != SYNC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_count <= '0;
        end else if (dp_s2 && !dp_d && dp_count != 8'hFF) begin
            dp_count <= dp_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_snake_seg_monitor.sv
// Scoreboard bench for snake_seg_monitor: expected move/error events are queued
// when a frame is driven and matched against each output pulse.
module tb_snake_seg_monitor;

    localparam int S  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_in = '0;
    logic          dp_in = 1'b0;
    logic [2:0]    head;
    logic          head_valid;
    logic          dir;
    logic          move_pulse;
    logic [CW-1:0] move_count;
    logic [7:0]    dp_count;
    logic          err_pulse;
    logic [1:0]    err_code;
    logic          locked;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        bit is_move;
        int cycle;
        int head;
        int dir;
        int cnt;
        int code;
        int lck;
    } exp_t;

    exp_t sb[$];

    snake_seg_monitor #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_in(seg_in),
        .dp_in(dp_in),
        .head(head),
        .head_valid(head_valid),
        .dir(dir),
        .move_pulse(move_pulse),
        .move_count(move_count),
        .dp_count(dp_count),
        .err_pulse(err_pulse),
        .err_code(err_code),
        .locked(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk_move(input int h, input int d, input int c);
        exp_t e;
        e = '{is_move: 1'b1, cycle: 0, head: h, dir: d, cnt: c, code: 0, lck: 1};
        return e;
    endfunction

    function automatic exp_t mk_err(input int code, input int lck);
        exp_t e;
        e = '{is_move: 1'b0, cycle: 0, head: 0, dir: 0, cnt: 0, code: code, lck: lck};
        return e;
    endfunction

    // Apply a frame at a falling edge and hold it; an expected event, if any,
    // is due at the falling edge after rising edge S+3.
    task automatic frame(input logic [6:0] f, input int hold, input bit push, input exp_t e);
        exp_t q;
        @(negedge clk);
        seg_in = f;
        if (push) begin
            q = e;
            q.cycle = cyc + S + 3;
            sb.push_back(q);
        end
        repeat (hold) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (move_pulse || err_pulse)) begin
            check("pulse_exclusive", {31'd0, move_pulse & err_pulse}, 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, move_pulse, err_pulse}, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {31'd0, move_pulse}, {31'd0, e.is_move});
                check("pulse_latency", cyc, e.cycle);
                if (e.is_move) begin
                    check("move_head", {29'd0, head}, e.head);
                    check("move_dir", {31'd0, dir}, e.dir);
                    check("move_count", {{(32-CW){1'b0}}, move_count}, e.cnt);
                    check("move_head_valid", {31'd0, head_valid}, 1);
                end else begin
                    check("err_code", {30'd0, err_code}, e.code);
                    check("err_locked", {31'd0, locked}, e.lck);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_head"}, {29'd0, head}, 0);
        check({tag, "_head_valid"}, {31'd0, head_valid}, 0);
        check({tag, "_dir"}, {31'd0, dir}, 0);
        check({tag, "_move_pulse"}, {31'd0, move_pulse}, 0);
        check({tag, "_move_count"}, {{(32-CW){1'b0}}, move_count}, 0);
        check({tag, "_dp_count"}, {24'd0, dp_count}, 0);
        check({tag, "_err_pulse"}, {31'd0, err_pulse}, 0);
        check({tag, "_err_code"}, {30'd0, err_code}, 0);
        check({tag, "_locked"}, {31'd0, locked}, 0);
    endtask

    logic [6:0] ring  [6];
    int         rhead [6];
    exp_t       none;

    initial begin
        none = mk_err(0, 0);
        ring[0] = 7'h07; ring[1] = 7'h0E; ring[2] = 7'h1C;
        ring[3] = 7'h38; ring[4] = 7'h31; ring[5] = 7'h23;
        rhead[0] = 2; rhead[1] = 3; rhead[2] = 4;
        rhead[3] = 5; rhead[4] = 0; rhead[5] = 1;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // clockwise pair of moves
        frame(7'h31, 10, 0, none);
        check("ref_locked", {31'd0, locked}, 1);
        check("ref_head_valid", {31'd0, head_valid}, 0);
        frame(7'h23, 10, 1, mk_move(1, 0, 1));
        frame(7'h07, 10, 1, mk_move(2, 0, 2));
        check("cw_head_valid", {31'd0, head_valid}, 1);
        check("cw_dir", {31'd0, dir}, 0);

        // error causes from TRACK
        frame(7'h16, 10, 1, mk_err(3, 1));
        check("adj_head_valid", {31'd0, head_valid}, 0);
        frame(7'h07, 10, 1, mk_move(0, 0, 3));
        frame(7'h58, 10, 1, mk_err(2, 1));
        frame(7'h0F, 10, 1, mk_err(1, 0));
        check("pop_locked", {31'd0, locked}, 0);
        check("pop_err_hold", {30'd0, err_code}, 1);

        // counter-clockwise move
        frame(7'h31, 10, 0, none);
        frame(7'h38, 10, 1, mk_move(3, 0, 4));
        frame(7'h1C, 10, 1, mk_move(2, 1, 5));
        check("ccw_dir", {31'd0, dir}, 1);

        // short glitch on a stable frame
        frame(7'h31, 10, 1, mk_err(2, 1));
        seg_in = 7'h23;
        repeat (S - 1) @(negedge clk);
        seg_in = 7'h31;
        repeat (12) @(negedge clk);
        check("glitch_count", {{(32-CW){1'b0}}, move_count}, 5);
        check("glitch_err_code", {30'd0, err_code}, 2);

        // reset in the middle of a pending move
        seg_in = 7'h23;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        check_all_zero("inreset");
        rst_n = 1'b1;
        repeat (S + 2) @(negedge clk);
        check("resync_early", {31'd0, locked}, 0);
        @(negedge clk);
        check("resync_locked", {31'd0, locked}, 1);
        check("resync_head_valid", {31'd0, head_valid}, 0);
        repeat (4) @(negedge clk);

        // lap the outer ring until move_count wraps
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            frame(ring[i % 6], 10, 1, mk_move(rhead[i % 6], 0, (i + 1) % (1 << CW)));
        end
        check("wrap_count", {{(32-CW){1'b0}}, move_count}, 2);

        // dp rising edges, saturating
        for (int i = 1; i <= 300; i++) begin
            dp_in = 1'b1;
            repeat (2) @(negedge clk);
            dp_in = 1'b0;
            repeat (2) @(negedge clk);
            if (i == 10 || i == 254 || i == 255 || i == 300)
                check($sformatf("dp_count_%0d", i), {24'd0, dp_count}, (i > 255) ? 255 : i);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
